// File: rtl/ball_serve_gen_if.sv
// Serve request / launch bundle between the game controller and ball_serve_gen.
// master = controller side (requests, reads launch fields), slave = ball_serve_gen.
interface ball_serve_gen_if;
  logic       i_serve_req;
  logic       i_serve_side;
  logic       i_cancel;
  logic [8:0] o_ball_y;
  logic       o_dir_x;
  logic       o_dir_y;
  logic [2:0] o_speed;
  logic       o_busy;
  logic       o_serve_valid;

  // i_serve_req is a level sampled only while idle; o_serve_valid is a one-cycle strobe with
  // no back-pressure, and the launch fields are stable whenever it is high.
  modport master (
    output i_serve_req, i_serve_side, i_cancel,
    input  o_ball_y, o_dir_x, o_dir_y, o_speed, o_busy, o_serve_valid
  );
  modport slave (
    input  i_serve_req, i_serve_side, i_cancel,
    output o_ball_y, o_dir_x, o_dir_y, o_speed, o_busy, o_serve_valid
  );
endinterface

// File: rtl/ball_serve_gen.sv
// Randomized ball launch: rejection-samples a start row from the LFSR word, waits SERVE_DELAY frames, strobes.
// Optional feature macro SERVE_RAND_SPEED_EN randomizes the launch speed from i_rand[1:0].
module ball_serve_gen #(
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 16,
  parameter int MARGIN      = 32,
  parameter int SERVE_DELAY = 60,
  parameter int MAX_RETRY   = 8,
  parameter int MIN_SPEED   = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [9:0]       i_rand,
  input  logic             i_frame_tick,
  ball_serve_gen_if.slave  sif,
  output logic [1:0]       o_state
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_DELAY  = 2'd2;
  localparam logic [1:0] ST_LAUNCH = 2'd3;

  localparam int DW = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [9:0]    Y_LO        = 10'(MARGIN);
  localparam logic [9:0]    Y_HI        = 10'(SCREEN_H - MARGIN - BALL_SIZE);
  localparam logic [8:0]    Y_CENTRE    = 9'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [2:0]    SPEED_BASE  = 3'(MIN_SPEED);
  localparam logic [DW-1:0] DELAY_LOAD  = DW'(SERVE_DELAY);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [8:0]    ball_y_q, ball_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic [2:0]    speed_q, speed_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;

  logic [9:0]    cand;
  logic          cand_ok;
  logic [2:0]    cand_speed;

  assign cand    = {1'b0, i_rand[8:0]};
  assign cand_ok = (cand >= Y_LO) && (cand <= Y_HI);

`ifdef SERVE_RAND_SPEED_EN
  assign cand_speed = SPEED_BASE + {1'b0, i_rand[1:0]};
`else
  assign cand_speed = SPEED_BASE;
`endif

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    delay_d  = delay_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    speed_d  = speed_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Cancel takes priority over a simultaneous request.
        if (!sif.i_cancel && sif.i_serve_req) begin
          state_d = ST_SAMPLE;
          busy_d  = 1'b1;
          dir_x_d = ~sif.i_serve_side;
          retry_d = '0;
        end
      end
      ST_SAMPLE: begin
        if (sif.i_cancel) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          retry_d = '0;
        end else if ((retry_q == RETRY_LIMIT) || cand_ok) begin
          // Retry budget exhausted: fall back to the centre row regardless of the candidate.
          ball_y_d = (retry_q == RETRY_LIMIT) ? Y_CENTRE : cand[8:0];
          dir_y_d  = i_rand[9];
          speed_d  = cand_speed;
          delay_d  = DELAY_LOAD;
          if (SERVE_DELAY == 0) begin
            state_d = ST_LAUNCH;
            valid_d = 1'b1;
          end else begin
            state_d = ST_DELAY;
          end
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      ST_DELAY: begin
        if (sif.i_cancel) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          retry_d = '0;
        end else if (i_frame_tick) begin
          delay_d = delay_q - DW'(1);
          if (delay_q == DW'(1)) begin
            state_d = ST_LAUNCH;
            valid_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        retry_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      delay_q  <= '0;
      ball_y_q <= Y_CENTRE;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      speed_q  <= SPEED_BASE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      delay_q  <= delay_d;
      ball_y_q <= ball_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      speed_q  <= speed_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign sif.o_ball_y      = ball_y_q;
  assign sif.o_dir_x       = dir_x_q;
  assign sif.o_dir_y       = dir_y_q;
  assign sif.o_speed       = speed_q;
  assign sif.o_busy        = busy_q;
  assign sif.o_serve_valid = valid_q;
  assign o_state           = state_q;
endmodule

// File: tb/tb_ball_serve_gen.sv
// Self-checking bench for ball_serve_gen: directed serves plus randomized serves against a behavioural model.
module tb_ball_serve_gen;
  localparam int SERVE_DELAY = 3;
  localparam int MAX_RETRY   = 8;
  localparam int MIN_SPEED   = 2;
  localparam int CENTRE      = 232;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rnd;
  logic       tick;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  ball_serve_gen_if bif ();

  ball_serve_gen #(
    .SCREEN_H(480), .BALL_SIZE(16), .MARGIN(32),
    .SERVE_DELAY(SERVE_DELAY), .MAX_RETRY(MAX_RETRY), .MIN_SPEED(MIN_SPEED)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rand(rnd), .i_frame_tick(tick),
    .sif(bif.slave), .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [9:0] w);
    return (int'(w[8:0]) >= 32) && (int'(w[8:0]) <= 432);
  endfunction

  function automatic int speed_of(input logic [9:0] w);
`ifdef SERVE_RAND_SPEED_EN
    return MIN_SPEED + int'(w[1:0]);
`else
    return MIN_SPEED;
`endif
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, bif.o_busy, 0);
    chk({tag, "_valid"}, bif.o_serve_valid, 0);
  endtask

  // One complete serve; the model decides when capture and launch must happen.
  task automatic serve(input bit side, input bit force_w, input logic [9:0] fw,
                       input bit hammer, input int cancel_at_tick, input bit cancel_in_sample);
    logic [9:0] w;
    int idx;
    int ticks;
    int gap;
    bit captured;
    int ey, edy, esp;
    bif.i_serve_req = 1'b1; bif.i_serve_side = side; bif.i_cancel = 1'b0;
    tick = 1'b0; rnd = 10'($urandom);
    step();
    bif.i_serve_req = hammer;
    chk("busy_after_req", bif.o_busy, 1);
    chk("valid_after_req", bif.o_serve_valid, 0);
    idx = 0; captured = 0; ey = 0; edy = 0; esp = 0;
    while (!captured) begin
      w = force_w ? fw : 10'($urandom);
      rnd = w;
      tick = 1'($urandom_range(0, 1));
      if (cancel_in_sample && idx == 2) begin
        bif.i_cancel = 1'b1;
        step();
        bif.i_cancel = 1'b0; bif.i_serve_req = 1'b0;
        chk_idle_outputs("cancel_sample");
        return;
      end
      if (idx == MAX_RETRY) begin
        ey = CENTRE; captured = 1;
      end else if (in_range(w)) begin
        ey = int'(w[8:0]); captured = 1;
      end
      edy = int'(w[9]);
      esp = speed_of(w);
      step();
      idx++;
      if (!captured) chk("busy_sampling", bif.o_busy, 1);
    end
    if (force_w && !in_range(fw)) chk("sample_cycles", idx, MAX_RETRY + 1);
    chk("cap_ball_y", bif.o_ball_y, ey);
    chk("cap_dir_y", bif.o_dir_y, edy);
    chk("cap_speed", bif.o_speed, esp);
    chk("cap_dir_x", bif.o_dir_x, !side);
    chk("cap_busy", bif.o_busy, 1);
    chk("cap_valid", bif.o_serve_valid, 0);
    ticks = 0;
    while (ticks < SERVE_DELAY) begin
      if (ticks == cancel_at_tick) begin
        bif.i_cancel = 1'b1; tick = 1'b0; rnd = 10'($urandom);
        step();
        bif.i_cancel = 1'b0; bif.i_serve_req = 1'b0;
        chk_idle_outputs("cancel_delay");
        for (int i = 0; i < 40; i++) begin
          tick = (i % 4 == 3); rnd = 10'($urandom);
          step();
          chk("post_cancel_valid", bif.o_serve_valid, 0);
        end
        chk("post_cancel_busy", bif.o_busy, 0);
        tick = 1'b0;
        return;
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick = 1'b0; rnd = 10'($urandom);
        step();
        chk("delay_gap_valid", bif.o_serve_valid, 0);
        chk("delay_gap_busy", bif.o_busy, 1);
      end
      tick = 1'b1; rnd = 10'($urandom);
      step();
      ticks++;
      if (ticks < SERVE_DELAY) begin
        chk("delay_tick_valid", bif.o_serve_valid, 0);
        chk("delay_tick_busy", bif.o_busy, 1);
      end
    end
    chk("launch_valid", bif.o_serve_valid, 1);
    chk("launch_busy", bif.o_busy, 1);
    chk("launch_ball_y", bif.o_ball_y, ey);
    chk("launch_dir_y", bif.o_dir_y, edy);
    chk("launch_speed", bif.o_speed, esp);
    chk("launch_dir_x", bif.o_dir_x, !side);
    // Cancel during the strobe cycle must have no effect on the launch.
    tick = 1'b0; bif.i_serve_req = 1'b0; bif.i_cancel = 1'($urandom_range(0, 1));
    rnd = 10'($urandom);
    step();
    bif.i_cancel = 1'b0;
    chk_idle_outputs("after_launch");
    chk("hold_ball_y", bif.o_ball_y, ey);
    chk("hold_speed", bif.o_speed, esp);
  endtask

  initial begin
    rst = 1'b1; rnd = '0; tick = 1'b0;
    bif.i_serve_req = 1'b0; bif.i_serve_side = 1'b0; bif.i_cancel = 1'b0;
    step(); step();
    chk("rst_ball_y", bif.o_ball_y, CENTRE);
    chk("rst_speed", bif.o_speed, MIN_SPEED);
    chk("rst_dir_x", bif.o_dir_x, 0);
    chk("rst_dir_y", bif.o_dir_y, 0);
    chk_idle_outputs("rst");
    rst = 1'b0;
    step();

    // Reset held two cycles in the middle of DELAY.
    bif.i_serve_req = 1'b1; bif.i_serve_side = 1'b1; rnd = 10'h064;
    step();
    bif.i_serve_req = 1'b0;
    step();
    chk("pre_rst_ball_y", bif.o_ball_y, 100);
    tick = 1'b1; step(); tick = 1'b0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    chk("midrst_ball_y", bif.o_ball_y, CENTRE);
    chk("midrst_speed", bif.o_speed, MIN_SPEED);
    chk("midrst_dir_x", bif.o_dir_x, 0);
    chk_idle_outputs("midrst");
    for (int i = 0; i < 12; i++) begin
      tick = (i % 2 == 0); rnd = 10'($urandom);
      step();
      chk("midrst_no_launch", bif.o_serve_valid, 0);
    end
    tick = 1'b0;

    serve(1'b0, 1'b1, 10'h064, 1'b0, -1, 1'b0);   // y=100, dir_x=1, dir_y=0
    serve(1'b1, 1'b1, 10'h1F0, 1'b0, -1, 1'b0);   // every candidate rejected -> centre
    serve(1'b0, 1'b1, 10'h064, 1'b0, 1, 1'b0);    // cancel after one frame tick
    serve(1'b1, 1'b1, 10'h1F0, 1'b0, -1, 1'b1);   // cancel while sampling
    serve(1'b0, 1'b0, 10'h000, 1'b1, -1, 1'b0);   // request held while busy
    serve(1'b1, 1'b1, 10'h2C3, 1'b0, -1, 1'b0);   // y=195, dir_y=1, speed depends on macro
    serve(1'b0, 1'b1, 10'h020, 1'b0, -1, 1'b0);   // lower bound 32 accepted
    serve(1'b1, 1'b1, 10'h1B0, 1'b0, -1, 1'b0);   // upper bound 432 accepted

    // Cancel together with a request in IDLE: stay idle.
    bif.i_serve_req = 1'b1; bif.i_cancel = 1'b1; rnd = 10'h064;
    step();
    bif.i_serve_req = 1'b0; bif.i_cancel = 1'b0;
    chk_idle_outputs("idle_cancel_req");
    step();
    chk_idle_outputs("idle_cancel_req2");

    for (int n = 0; n < 20; n++) begin
      serve(1'($urandom_range(0, 1)), 1'b0, 10'h000, 1'($urandom_range(0, 1)), -1, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        rnd = 10'($urandom); tick = 1'($urandom_range(0, 1));
        step();
        chk("idle_gap_valid", bif.o_serve_valid, 0);
      end
      tick = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
